// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default data width and register count, the register-address width,
// the zero-register constant, and helpers that locate one requester's fields
// inside the packed request buses.
package regfile_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  // LSB of requester idx's destination field in the packed req_rd bus
  function automatic int unsigned rd_lsb(input int unsigned idx);
    return idx * REG_AW;
  endfunction

  // LSB of requester idx's data field in the packed req_data bus
  function automatic int unsigned data_lsb(input int unsigned idx, input int unsigned xlen);
    return idx * xlen;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic N-way round-robin arbiter with pointer state.
// Ports:
//   clk, reset : clock, synchronous active-high reset (pointer -> 0)
//   req        : request vector
//   advance    : a grant was accepted; pointer moves past the winner
//   grant      : one-hot grant, combinational from req and the pointer
//   idx        : binary index of the granted requester
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;
  logic [IW:0]   cand;
  logic          found;

  // Search upward from the pointer, wrapping at N; first requester found wins
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found              = 1'b1;
        grant[cand[IW-1:0]] = 1'b1;
        idx                = cand[IW-1:0];
      end
    end
  end

  // Next pointer is one past the winner, modulo N
  always_comb begin
    rr_ptr_d = (idx == IW'(N-1)) ? '0 : idx + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else if (advance) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with RAW busy scoreboard.
// Shares the single register-file write port among N_REQ writeback sources
// (index 0 = ALU pipe) and tracks registers owned by in-flight multi-cycle ops.
// Build option: REGFILE_WB_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins) in place of round-robin.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   req_valid/req_ready     : per-requester handshake (ready is combinational)
//   req_rd/req_data         : packed per-requester destination and data
//   wb_en/wb_reg/wb_data    : registered register-file write port
//   alloc_valid/alloc_reg   : multi-cycle dispatch marks alloc_reg busy
//   rs1/rs2, rs1_busy/rs2_busy : issue-stage hazard queries (combinational)
//   busy_vec                : registered scoreboard
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned XLEN  = regfile_pkg::XLEN,
  parameter int unsigned NREG  = regfile_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*REG_AW-1:0] req_rd,
  input  logic [N_REQ*XLEN-1:0]   req_data,
  output logic                    wb_en,
  output logic [REG_AW-1:0]       wb_reg,
  output logic [XLEN-1:0]         wb_data,
  input  logic                    alloc_valid,
  input  logic [REG_AW-1:0]       alloc_reg,
  input  logic [REG_AW-1:0]       rs1,
  input  logic [REG_AW-1:0]       rs2,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [NREG-1:0]         busy_vec
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  req_c;
  logic [N_REQ-1:0]  grant_c;
  logic [IW-1:0]     gidx_c;
  logic              hs_c;
  logic [REG_AW-1:0] g_rd_c;
  logic [XLEN-1:0]   g_data_c;

  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_reg_q;
  logic [XLEN-1:0]   wb_data_q;
  logic [NREG-1:0]   busy_q, busy_d;

  // Nothing is granted while reset is held
  assign req_c = reset ? '0 : req_valid;

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
  // Priority encoder: lowest valid index wins
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_c[i]) begin
        grant_c = '0;
        grant_c[i] = 1'b1;
        gidx_c  = IW'(i);
      end
    end
  end
`else
  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .reset   (reset),
    .req     (req_c),
    .advance (hs_c),
    .grant   (grant_c),
    .idx     (gidx_c)
  );
`endif

  assign hs_c      = |grant_c;
  assign req_ready = grant_c;
  assign g_rd_c    = req_rd[rd_lsb(32'(gidx_c)) +: REG_AW];
  assign g_data_c  = req_data[data_lsb(32'(gidx_c), XLEN) +: XLEN];

  // Scoreboard next state: clear on writeback, then set on alloc so set wins
  always_comb begin
    busy_d  = busy_q;
    wb_en_d = hs_c && (g_rd_c != ZERO_REG);
    if (wb_en_d) begin
      busy_d[g_rd_c] = 1'b0;
    end
    if (alloc_valid && (alloc_reg != ZERO_REG)) begin
      busy_d[alloc_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wb_en_q <= wb_en_d;
      if (hs_c) begin
        wb_reg_q  <= g_rd_c;
        wb_data_q <= g_data_c;
      end
      busy_q <= busy_d;
    end
  end

  assign wb_en    = wb_en_q;
  assign wb_reg   = wb_reg_q;
  assign wb_data  = wb_data_q;
  assign busy_vec = busy_q;
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter (N_REQ=3, XLEN=32, NREG=32).
module tb_regfile_wb_arbiter;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        alloc_valid;
  logic [4:0]  alloc_reg;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic [31:0] busy_vec;

  logic [4:0]  rd_a  [3];
  logic [31:0] dat_a [3];

  int n_vec;
  int n_err;

  wb_t         sb_q[$];
  int          m_ptr;
  logic [31:0] m_busy;
  logic [2:0]  m_grant;

  regfile_wb_arbiter #(.N_REQ(3), .XLEN(32), .NREG(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .alloc_valid (alloc_valid),
    .alloc_reg   (alloc_reg),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .busy_vec    (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      req_rd[i*5 +: 5]    = rd_a[i];
      req_data[i*32 +: 32] = dat_a[i];
    end
  end

  // Reference model, evaluated mid-cycle: grant, scoreboard, query outputs
  always @(negedge clk) begin
    logic [2:0]  eg;
    logic        hs;
    int          g;
    logic [31:0] nb;
    eg = '0; hs = 1'b0; g = 0;
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_ptr + k) % 3;
`endif
        if (!hs && req_valid[idx]) begin
          hs = 1'b1; g = idx; eg[idx] = 1'b1;
        end
      end
    end
    n_vec++;
    if (req_ready !== eg) begin
      n_err++; $display("FAIL model_grant: req_ready=%b expected %b at %0t", req_ready, eg, $time);
    end
    n_vec++;
    if (busy_vec !== m_busy) begin
      n_err++; $display("FAIL model_busy: busy_vec=%h expected %h at %0t", busy_vec, m_busy, $time);
    end
    n_vec++;
    if (rs1_busy !== m_busy[rs1] || rs2_busy !== m_busy[rs2]) begin
      n_err++; $display("FAIL model_query: rs1_busy=%b rs2_busy=%b expected %b %b at %0t",
                        rs1_busy, rs2_busy, m_busy[rs1], m_busy[rs2], $time);
    end
    sb_q.push_back('{en: hs && (rd_a[g] != 5'd0), rd: rd_a[g], data: dat_a[g]});
    m_grant = eg;
    nb = m_busy;
    if (reset) begin
      m_ptr = 0; nb = '0;
    end else begin
      if (hs) m_ptr = (g + 1) % 3;
      if (hs && rd_a[g] != 5'd0) nb[rd_a[g]] = 1'b0;
      if (alloc_valid && alloc_reg != 5'd0) nb[alloc_reg] = 1'b1;
      nb[0] = 1'b0;
    end
    m_busy = nb;
  end

  // Scoreboard: each cycle's expected writeback is checked one edge later
  always @(posedge clk) begin
    wb_t e;
    #2;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (wb_en !== e.en) begin
        n_err++; $display("FAIL sb_wb_en: wb_en=%b expected %b at %0t", wb_en, e.en, $time);
      end
      if (e.en) begin
        n_vec++;
        if (wb_reg !== e.rd || wb_data !== e.data) begin
          n_err++; $display("FAIL sb_wb_payload: reg=%0d data=%h expected reg=%0d data=%h at %0t",
                            wb_reg, wb_data, e.rd, e.data, $time);
        end
      end
    end
  end

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) next_cycle();
    n_vec++;
    if (wb_en !== 1'b0 || wb_reg !== 5'd0 || wb_data !== 32'd0 || busy_vec !== 32'd0 || req_ready !== 3'b000) begin
      n_err++; $display("FAIL reset_state: en=%b reg=%0d data=%h busy=%h ready=%b", wb_en, wb_reg, wb_data, busy_vec, req_ready);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      n_vec++;
      if (wb_en !== 1'b0 || busy_vec !== 32'd0 || req_ready !== 3'b000) begin
        n_err++; $display("FAIL idle_after_reset: cycle %0d en=%b busy=%h ready=%b", c, wb_en, busy_vec, req_ready);
      end
    end
  endtask

  task automatic test_single;
    req_valid = 3'b001; rd_a[0] = 5'd5; dat_a[0] = 32'hDEADBEEF;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL single_grant: ready=%b expected 001", req_ready);
    end
    next_cycle();
    req_valid = 3'b000;
    n_vec++;
    if (wb_en !== 1'b1 || wb_reg !== 5'd5 || wb_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_wb: en=%b reg=%0d data=%h expected 1 5 deadbeef", wb_en, wb_reg, wb_data);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] pat [4];
`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
    pat = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    pat = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    rd_a[0] = 5'd1; rd_a[1] = 5'd2; rd_a[2] = 5'd3;
    dat_a[0] = 32'hA0A0_0001; dat_a[1] = 32'hB0B0_0002; dat_a[2] = 32'hC0C0_0003;
    req_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_ready !== pat[c]) begin
        n_err++; $display("FAIL rr_sequence: cycle %0d ready=%b expected %b", c, req_ready, pat[c]);
      end
      next_cycle();
    end
    req_valid = 3'b000;
  endtask

  task automatic test_scoreboard;
    rs1 = 5'd7; alloc_valid = 1'b1; alloc_reg = 5'd7;
    @(negedge clk);
    n_vec++;
    if (rs1_busy !== 1'b0) begin
      n_err++; $display("FAIL sb_no_forward: rs1_busy=%b expected 0", rs1_busy);
    end
    next_cycle();
    alloc_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (rs1_busy !== 1'b1 || busy_vec[7] !== 1'b1) begin
      n_err++; $display("FAIL sb_set: rs1_busy=%b busy[7]=%b expected 1 1", rs1_busy, busy_vec[7]);
    end
    next_cycle();
    next_cycle();
    req_valid = 3'b100; rd_a[2] = 5'd7; dat_a[2] = 32'h0000_7777;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b100 || rs1_busy !== 1'b1) begin
      n_err++; $display("FAIL sb_handshake: ready=%b rs1_busy=%b expected 100 1", req_ready, rs1_busy);
    end
    next_cycle();
    req_valid = 3'b000;
    @(negedge clk);
    n_vec++;
    if (rs1_busy !== 1'b0 || wb_reg !== 5'd7 || wb_en !== 1'b1) begin
      n_err++; $display("FAIL sb_clear: rs1_busy=%b wb_reg=%0d wb_en=%b expected 0 7 1", rs1_busy, wb_reg, wb_en);
    end
  endtask

  task automatic test_set_clear;
    alloc_valid = 1'b1; alloc_reg = 5'd9;
    next_cycle();
    req_valid = 3'b010; rd_a[1] = 5'd9; dat_a[1] = 32'h9999_0009;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b010) begin
      n_err++; $display("FAIL conflict_grant: ready=%b expected 010", req_ready);
    end
    next_cycle();
    req_valid = 3'b000; alloc_reg = 5'd0;
    n_vec++;
    if (busy_vec[9] !== 1'b1) begin
      n_err++; $display("FAIL conflict_set_wins: busy[9]=%b expected 1", busy_vec[9]);
    end
    next_cycle();
    alloc_valid = 1'b0;
    n_vec++;
    if (busy_vec[0] !== 1'b0 || busy_vec[9] !== 1'b1) begin
      n_err++; $display("FAIL zero_reg_alloc: busy[0]=%b busy[9]=%b expected 0 1", busy_vec[0], busy_vec[9]);
    end
    req_valid = 3'b001; rd_a[0] = 5'd9; dat_a[0] = 32'h0000_0900;
    next_cycle();
    req_valid = 3'b000;
    n_vec++;
    if (busy_vec[9] !== 1'b0) begin
      n_err++; $display("FAIL conflict_later_clear: busy[9]=%b expected 0", busy_vec[9]);
    end
  endtask

  task automatic test_rd_zero;
    alloc_valid = 1'b1; alloc_reg = 5'd4;
    next_cycle();
    alloc_valid = 1'b0;
    req_valid = 3'b001; rd_a[0] = 5'd0; dat_a[0] = 32'h0000_1234;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL rd0_grant: ready=%b expected 001", req_ready);
    end
    next_cycle();
    req_valid = 3'b000;
    n_vec++;
    if (wb_en !== 1'b0 || busy_vec !== 32'h0000_0010) begin
      n_err++; $display("FAIL rd0_suppressed: wb_en=%b busy=%h expected 0 00000010", wb_en, busy_vec);
    end
  endtask

  task automatic test_reset_pending;
    alloc_valid = 1'b1; alloc_reg = 5'd12;
    next_cycle();
    alloc_valid = 1'b0;
    rd_a[0] = 5'd1; rd_a[1] = 5'd2; rd_a[2] = 5'd3;
    req_valid = 3'b111; reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b000) begin
      n_err++; $display("FAIL reset_no_grant: ready=%b expected 000", req_ready);
    end
    next_cycle();
    n_vec++;
    if (busy_vec !== 32'd0 || wb_en !== 1'b0) begin
      n_err++; $display("FAIL reset_clears: busy=%h wb_en=%b expected 0 0", busy_vec, wb_en);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 3'b001) begin
      n_err++; $display("FAIL reset_represent: ready=%b expected 001", req_ready);
    end
    next_cycle();
    req_valid = 3'b000;
  endtask

  // Random traffic obeying the requester contract, checked by the model
  task automatic test_back_to_back;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] || m_grant[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          rd_a[i]      = 5'($urandom_range(0, 31));
          dat_a[i]     = $urandom;
        end
      end
      alloc_valid = 1'($urandom_range(0, 1));
      alloc_reg   = 5'($urandom_range(0, 31));
      rs1         = 5'($urandom_range(0, 31));
      rs2         = 5'($urandom_range(0, 31));
      next_cycle();
    end
    req_valid = 3'b000; alloc_valid = 1'b0;
    repeat (3) next_cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    m_ptr = 0; m_busy = '0; m_grant = '0;
    reset = 1'b1; req_valid = '0; alloc_valid = 1'b0; alloc_reg = '0;
    rs1 = '0; rs2 = '0;
    for (int i = 0; i < 3; i++) begin
      rd_a[i] = '0; dat_a[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_set_clear();
    test_rd_zero();
    test_reset_pending();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
